pedest_xing_ctrl: RTL

Crossing-sequence controller for the pedestrian button device. It consumes the button's data-available request and acknowledges it so the device's DBA bit clears. It sequences car and pedestrian signal phases with programmable dwell times. A status byte is exported for the CPU's device-register read path.

---
 rtl/pedest_xing_ctrl_if.sv | 21 ++
 rtl/pedest_xing_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/pedest_xing_ctrl_if.sv
// Bus between the pedestrian button device / CPU register path and the crossing controller.
// The master drives the request side; the slave returns ack, lights and the status byte.
interface pedest_xing_ctrl_if;
  logic       enable;
  logic       ped_req;
  logic       dba_ack;
  logic [2:0] car_lights;
  logic [1:0] ped_lights;
  logic       pending;
  logic [7:0] status;

  modport master (
    output enable, ped_req,
    input  dba_ack, car_lights, ped_lights, pending, status
  );

  modport slave (
    input  enable, ped_req,
    output dba_ack, car_lights, ped_lights, pending, status
  );
endinterface

// File: rtl/pedest_xing_ctrl.sv
// Crossing sequencer GREEN->YELLOW->RED1->WALK->FLASH->RED2 with per-phase dwell counters.
// Lights are Moore outputs of registered state; dba_ack is same-cycle and ped_req is never stalled.
module pedest_xing_ctrl #(
  parameter int CNT_W       = 8,
  parameter int T_MIN_GREEN = 16,
  parameter int T_YELLOW    = 4,
  parameter int T_ALL_RED   = 2,
  parameter int T_WALK      = 8,
  parameter int T_FLASH     = 6,
  parameter int FLASH_HALF  = 1
) (
  input logic               clk,
  input logic               reset_n,
  pedest_xing_ctrl_if.slave bus
);

  localparam logic [2:0] S_GREEN  = 3'd0;
  localparam logic [2:0] S_YELLOW = 3'd1;
  localparam logic [2:0] S_RED1   = 3'd2;
  localparam logic [2:0] S_WALK   = 3'd3;
  localparam logic [2:0] S_FLASH  = 3'd4;
  localparam logic [2:0] S_RED2   = 3'd5;

  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_RED    = CNT_W'(T_ALL_RED - 1);
  localparam logic [CNT_W-1:0] LD_WALK   = CNT_W'(T_WALK - 1);
  localparam logic [CNT_W-1:0] LD_FLASH  = CNT_W'(T_FLASH - 1);
  localparam logic [CNT_W-1:0] LD_HALF   = CNT_W'(FLASH_HALF - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] dwell;
  logic [CNT_W-1:0] dwell_ld;
  logic [CNT_W-1:0] flash_cnt;
  logic             pending_q;
  logic             toggle;
  logic             req_take;
  logic             serving;
  logic             cnt_done;
  logic             enter_walk;

  assign req_take   = reset_n & bus.enable & bus.ped_req;
  assign serving    = (state == S_WALK) || (state == S_FLASH);
  assign cnt_done   = (dwell == '0);
  assign enter_walk = (state_nxt == S_WALK) && (state != S_WALK);

  always_comb begin
    state_nxt = state;
    case (state)
      S_GREEN:  if (cnt_done && pending_q) state_nxt = S_YELLOW;
      S_YELLOW: if (cnt_done) state_nxt = S_RED1;
      S_RED1:   if (cnt_done) state_nxt = S_WALK;
      S_WALK:   if (cnt_done) state_nxt = S_FLASH;
      S_FLASH:  if (cnt_done) state_nxt = S_RED2;
      S_RED2:   if (cnt_done) state_nxt = S_GREEN;
      default:  state_nxt = S_GREEN;
    endcase
  end

  always_comb begin
    dwell_ld = LD_GREEN;
    case (state_nxt)
      S_YELLOW:       dwell_ld = LD_YELLOW;
      S_RED1, S_RED2: dwell_ld = LD_RED;
      S_WALK:         dwell_ld = LD_WALK;
      S_FLASH:        dwell_ld = LD_FLASH;
      default:        dwell_ld = LD_GREEN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_GREEN;
      dwell     <= LD_GREEN;
      pending_q <= 1'b0;
      toggle    <= 1'b1;
      flash_cnt <= LD_HALF;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        dwell <= dwell_ld;
      end else if (!cnt_done) begin
        dwell <= dwell - ONE;
      end

      // A request landing on the WALK entry edge is discarded, so clear has priority.
      if (enter_walk) begin
        pending_q <= 1'b0;
      end else if (req_take && !serving) begin
        pending_q <= 1'b1;
      end

      if (state_nxt != S_FLASH || state != S_FLASH) begin
        toggle    <= 1'b1;
        flash_cnt <= LD_HALF;
      end else if (flash_cnt == '0) begin
        toggle    <= ~toggle;
        flash_cnt <= LD_HALF;
      end else begin
        flash_cnt <= flash_cnt - ONE;
      end
    end
  end

  always_comb begin
    bus.car_lights = 3'b100;
    bus.ped_lights = 2'b01;
    case (state)
      S_GREEN:  bus.car_lights = 3'b001;
      S_YELLOW: bus.car_lights = 3'b010;
      S_WALK:   bus.ped_lights = 2'b10;
      S_FLASH:  bus.ped_lights = {1'b0, toggle};
      default:  bus.car_lights = 3'b100;
    endcase
  end

  assign bus.dba_ack = req_take;
  assign bus.pending = pending_q;
  assign bus.status  = {3'b000, pending_q, bus.enable, state};

endmodule
